game_round_scheduler: RTL and testbench

Sequences one hide-and-seek round after the menu FSM raises game_started. It runs a hide countdown and then a seek countdown whose length comes from time_setting. It ends the round on timeout (hider wins) or on a catch event (seeker wins), and raises game_done/winner back to the menu and display logic. It owns the 1 Hz game time base shared by the HUD and the game logic.

---
 rtl/game_round_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_game_round_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : game_round_scheduler
// Description : Sequences one hide-and-seek round: hide countdown, seek
//               countdown sized by time_setting, and the round result
//               (timeout -> hider wins, catch -> seeker wins). Owns the
//               1 Hz game time base shared by the HUD and the game logic.
// Revision    : 1.0 - initial release
// ============================================================================
module game_round_scheduler #(
  parameter int TICK_DIV      = 100000000, // clk cycles per game second
  parameter int HIDE_SECONDS  = 10,        // hide-phase length in seconds
  parameter int TIME_UNIT_SEC = 60         // seconds per time_setting unit
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_started,
  input  logic [7:0] time_setting,
  input  logic       caught,
  input  logic       pause,
  output logic [1:0] phase,
  output logic [9:0] seconds_left,
  output logic       sec_tick,
  output logic       game_done,
  output logic       winner
);

  // Prescaler sizing; a width of at least one bit keeps degenerate settings legal.
  localparam int c_presc_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);

  // Phase load values, all in the 10-bit seconds domain.
  localparam logic [9:0] c_hide_sec = 10'(HIDE_SECONDS);
  localparam logic [9:0] c_len1     = 10'(1 * TIME_UNIT_SEC);
  localparam logic [9:0] c_len2     = 10'(2 * TIME_UNIT_SEC);
  localparam logic [9:0] c_len3     = 10'(3 * TIME_UNIT_SEC);
  localparam logic [9:0] c_len4     = 10'(4 * TIME_UNIT_SEC);

  // Phase encoding is visible on the phase port, so the values are pinned.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIDE = 2'd1,
    ST_SEEK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Registered state
  state_t                r_state;
  logic                  r_started_q;
  logic [c_presc_w-1:0]  r_presc;
  logic [9:0]            r_seconds_left;
  logic [9:0]            r_round_len;
  logic                  r_sec_tick;
  logic                  r_game_done;
  logic                  r_winner;

  // Next-state values
  state_t                w_state_nxt;
  logic [c_presc_w-1:0]  w_presc_nxt;
  logic [9:0]            w_seconds_nxt;
  logic [9:0]            w_round_len_nxt;
  logic                  w_tick_nxt;
  logic                  w_done_nxt;
  logic                  w_winner_nxt;

  // Helper terms
  logic                  w_rise;
  logic                  w_wrap;
  logic                  w_last_sec;
  logic [c_presc_w-1:0]  w_presc_adv;
  logic [9:0]            w_round_len_new;

  assign w_rise     = game_started & ~r_started_q;
  // A game second elapses only on an unpaused cycle at the top of the prescaler.
  assign w_wrap     = ~pause & (r_presc == c_presc_max);
  assign w_last_sec = (r_seconds_left == 10'd1);

  // Clamp the requested round length to 1..4 units before scaling.
  always_comb begin
    w_round_len_new = c_len1;
    if (time_setting >= 8'd4) begin
      w_round_len_new = c_len4;
    end else if (time_setting == 8'd3) begin
      w_round_len_new = c_len3;
    end else if (time_setting == 8'd2) begin
      w_round_len_new = c_len2;
    end
  end

  // Prescaler advance used while a countdown is running: hold, wrap or count.
  always_comb begin
    w_presc_adv = r_presc;
    if (!pause) begin
      if (r_presc == c_presc_max) begin
        w_presc_adv = '0;
      end else begin
        w_presc_adv = r_presc + 1'b1;
      end
    end
  end

  // Next-state and output decode; abort beats catch, catch beats the final tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_seconds_nxt   = r_seconds_left;
    w_round_len_nxt = r_round_len;
    w_tick_nxt      = 1'b0;
    w_done_nxt      = r_game_done;
    w_winner_nxt    = r_winner;

    case (r_state)
      ST_IDLE: begin
        w_presc_nxt  = '0;
        w_done_nxt   = 1'b0;
        w_winner_nxt = 1'b0;
        if (w_rise) begin
          w_state_nxt     = ST_HIDE;
          w_seconds_nxt   = c_hide_sec;
          w_round_len_nxt = w_round_len_new;
        end
      end

      ST_HIDE: begin
        if (!game_started) begin
          w_state_nxt   = ST_IDLE;
          w_seconds_nxt = 10'd0;
          w_presc_nxt   = '0;
        end else begin
          w_presc_nxt = w_presc_adv;
          if (w_wrap) begin
            w_tick_nxt = 1'b1;
            if (w_last_sec) begin
              // Hide phase over: seek countdown restarts the prescaler.
              w_state_nxt   = ST_SEEK;
              w_seconds_nxt = r_round_len;
              w_presc_nxt   = '0;
            end else begin
              w_seconds_nxt = r_seconds_left - 10'd1;
            end
          end
        end
      end

      ST_SEEK: begin
        if (!game_started) begin
          w_state_nxt   = ST_IDLE;
          w_seconds_nxt = 10'd0;
          w_presc_nxt   = '0;
        end else if (caught) begin
          // Seeker wins; the remaining time is left on display.
          w_state_nxt  = ST_DONE;
          w_done_nxt   = 1'b1;
          w_winner_nxt = 1'b0;
          w_presc_nxt  = '0;
        end else begin
          w_presc_nxt = w_presc_adv;
          if (w_wrap) begin
            w_tick_nxt = 1'b1;
            if (w_last_sec) begin
              // Timeout: hider wins.
              w_state_nxt   = ST_DONE;
              w_done_nxt    = 1'b1;
              w_winner_nxt  = 1'b1;
              w_seconds_nxt = 10'd0;
              w_presc_nxt   = '0;
            end else begin
              w_seconds_nxt = r_seconds_left - 10'd1;
            end
          end
        end
      end

      ST_DONE: begin
        w_presc_nxt = '0;
        if (!game_started) begin
          w_state_nxt   = ST_IDLE;
          w_done_nxt    = 1'b0;
          w_winner_nxt  = 1'b0;
          w_seconds_nxt = 10'd0;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_presc_nxt   = '0;
        w_seconds_nxt = 10'd0;
        w_done_nxt    = 1'b0;
        w_winner_nxt  = 1'b0;
      end
    endcase
  end

  // State register; reset overrides every other input in every phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_started_q    <= 1'b0;
      r_presc        <= '0;
      r_seconds_left <= 10'd0;
      r_round_len    <= 10'd0;
      r_sec_tick     <= 1'b0;
      r_game_done    <= 1'b0;
      r_winner       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_started_q    <= game_started;
      r_presc        <= w_presc_nxt;
      r_seconds_left <= w_seconds_nxt;
      r_round_len    <= w_round_len_nxt;
      r_sec_tick     <= w_tick_nxt;
      r_game_done    <= w_done_nxt;
      r_winner       <= w_winner_nxt;
    end
  end

  assign phase        = r_state;
  assign seconds_left = r_seconds_left;
  assign sec_tick     = r_sec_tick;
  assign game_done    = r_game_done;
  assign winner       = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_game_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_round_scheduler
// Description : Directed self-checking bench for game_round_scheduler using a
//               queue of expected output vectors checked one per clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_round_scheduler;

  localparam int TDIV = 4;
  localparam int HS   = 3;
  localparam int UNIT = 5;

  logic       clk;
  logic       reset;
  logic       game_started;
  logic [7:0] time_setting;
  logic       caught;
  logic       pause;
  logic [1:0] phase;
  logic [9:0] seconds_left;
  logic       sec_tick;
  logic       game_done;
  logic       winner;

  int n_cmp = 0;
  int n_err = 0;

  // Expected vector layout: {phase[14:13], seconds_left[12:3], tick, done, winner}
  typedef struct {
    string       tag;
    logic [14:0] exp;
    logic [14:0] msk;
  } exp_t;

  exp_t sb_q[$];

  game_round_scheduler #(
    .TICK_DIV      (TDIV),
    .HIDE_SECONDS  (HS),
    .TIME_UNIT_SEC (UNIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .game_started (game_started),
    .time_setting (time_setting),
    .caught       (caught),
    .pause        (pause),
    .phase        (phase),
    .seconds_left (seconds_left),
    .sec_tick     (sec_tick),
    .game_done    (game_done),
    .winner       (winner)
  );

  // 100 MHz-style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge, then pop the oldest expectation and compare it.
  task automatic step();
    exp_t        e;
    logic [14:0] obs;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = {phase, seconds_left, sec_tick, game_done, winner};
      n_cmp++;
      assert ((obs & e.msk) === (e.exp & e.msk))
      else begin
        n_err++;
        $error("FAIL %s: observed ph=%0d sl=%0d tick=%0d done=%0d win=%0d expected ph=%0d sl=%0d tick=%0d done=%0d win=%0d",
               e.tag, obs[14:13], obs[12:3], obs[2], obs[1], obs[0],
               e.exp[14:13], e.exp[12:3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  // Push the expected result of the next edge, then take that edge.
  // sl < 0 means seconds_left is not checked for this edge.
  task automatic chk(input string tag, input int ph, input int sl,
                     input int tk, input int dn, input int wn);
    exp_t e;
    e.tag = tag;
    e.exp = {2'(ph), 10'(sl), 1'(tk), 1'(dn), 1'(wn)};
    e.msk = '1;
    if (sl < 0) e.msk[12:3] = 10'd0;
    sb_q.push_back(e);
    step();
  endtask

  // One game second from a freshly wrapped prescaler: TDIV-1 quiet edges, then the tick edge.
  task automatic run_sec(input string tag, input int ph, input int sl,
                         input int ph_n, input int sl_n, input int dn, input int wn);
    for (int i = 0; i < TDIV - 1; i++) chk(tag, ph, sl, 0, 0, 0);
    chk(tag, ph_n, sl_n, 1, dn, wn);
  endtask

  // Raise game_started from IDLE and run through the hide phase into SEEK.
  task automatic start_round(input string tag, input int ts, input int ts_after, input int load);
    time_setting = 8'(ts);
    game_started = 1'b1;
    chk({tag, "_rise"}, 1, HS, 0, 0, 0);
    time_setting = 8'(ts_after);
    run_sec({tag, "_hide"}, 1, HS,     1, HS - 1, 0, 0);
    run_sec({tag, "_hide"}, 1, HS - 1, 1, HS - 2, 0, 0);
    run_sec({tag, "_load"}, 1, HS - 2, 2, load,   0, 0);
  endtask

  initial begin
    reset        = 1'b1;
    game_started = 1'b0;
    time_setting = 8'd0;
    caught       = 1'b0;
    pause        = 1'b0;

    // Reset state
    chk("reset0", 0, 0, 0, 0, 0);
    chk("reset1", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // 1. Timeout round: hider wins
    start_round("s1", 2, 2, 2 * UNIT);
    for (int s = 2 * UNIT; s >= 2; s--) run_sec("s1_seek", 2, s, 2, s - 1, 0, 0);
    run_sec("s1_timeout", 2, 1, 3, 0, 1, 1);
    chk("s1_done", 3, 0, 0, 1, 1);
    chk("s1_done", 3, 0, 0, 1, 1);
    game_started = 1'b0;
    chk("s1_exit", 0, -1, 0, 0, 0);

    // 2. Catch ignored in HIDE, honoured in SEEK at 6 seconds left
    time_setting = 8'd2;
    game_started = 1'b1;
    chk("s2_rise", 1, HS, 0, 0, 0);
    caught = 1'b1;
    chk("s2_hide_caught", 1, HS, 0, 0, 0);
    caught = 1'b0;
    chk("s2_hide", 1, HS, 0, 0, 0);
    chk("s2_hide", 1, HS, 0, 0, 0);
    chk("s2_hide_tick", 1, HS - 1, 1, 0, 0);
    run_sec("s2_hide", 1, HS - 1, 1, HS - 2, 0, 0);
    run_sec("s2_load", 1, HS - 2, 2, 2 * UNIT, 0, 0);
    for (int s = 2 * UNIT; s >= 7; s--) run_sec("s2_seek", 2, s, 2, s - 1, 0, 0);
    caught = 1'b1;
    chk("s2_catch", 3, 6, 0, 1, 0);
    caught = 1'b0;
    chk("s2_done_hold", 3, 6, 0, 1, 0);
    game_started = 1'b0;
    chk("s2_exit", 0, -1, 0, 0, 0);

    // 3. Clamping and latch of time_setting
    start_round("s3_ts0", 0, 0, UNIT);
    game_started = 1'b0;
    chk("s3_abort", 0, 0, 0, 0, 0);
    start_round("s3_ts3", 3, 3, 3 * UNIT);
    game_started = 1'b0;
    chk("s3_abort", 0, 0, 0, 0, 0);
    start_round("s3_ts255", 255, 255, 4 * UNIT);
    game_started = 1'b0;
    chk("s3_abort", 0, 0, 0, 0, 0);
    start_round("s3_latch", 2, 4, 2 * UNIT);
    game_started = 1'b0;
    chk("s3_abort", 0, 0, 0, 0, 0);

    // 4. Pause in SEEK with the prescaler at 2
    start_round("s4", 1, 1, UNIT);
    chk("s4_run", 2, UNIT, 0, 0, 0);
    chk("s4_run", 2, UNIT, 0, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) chk("s4_paused", 2, UNIT, 0, 0, 0);
    pause = 1'b0;
    chk("s4_resume", 2, UNIT, 0, 0, 0);
    chk("s4_tick", 2, UNIT - 1, 1, 0, 0);
    pause = 1'b1;
    chk("s4_paused2", 2, UNIT - 1, 0, 0, 0);
    caught = 1'b1;
    chk("s4_catch_paused", 3, UNIT - 1, 0, 1, 0);
    caught = 1'b0;
    pause  = 1'b0;
    game_started = 1'b0;
    chk("s4_exit", 0, -1, 0, 0, 0);

    // 5. Races: catch vs final tick, abort vs catch, abort in HIDE
    start_round("s5", 1, 1, UNIT);
    for (int s = UNIT; s >= 2; s--) run_sec("s5_seek", 2, s, 2, s - 1, 0, 0);
    for (int i = 0; i < TDIV - 1; i++) chk("s5_last", 2, 1, 0, 0, 0);
    caught = 1'b1;
    chk("s5_race", 3, 1, 0, 1, 0);
    caught = 1'b0;
    chk("s5_race_hold", 3, 1, 0, 1, 0);
    game_started = 1'b0;
    chk("s5_exit", 0, -1, 0, 0, 0);
    start_round("s5b", 1, 1, UNIT);
    caught       = 1'b1;
    game_started = 1'b0;
    chk("s5_abort_over_catch", 0, 0, 0, 0, 0);
    caught = 1'b0;
    game_started = 1'b1;
    chk("s5c_rise", 1, HS, 0, 0, 0);
    game_started = 1'b0;
    chk("s5_abort_hide", 0, 0, 0, 0, 0);

    // 6. DONE held while game_started stays high, then exit; reset mid-SEEK
    start_round("s6", 9, 9, 4 * UNIT);
    caught = 1'b1;
    chk("s6_catch", 3, 4 * UNIT, 0, 1, 0);
    caught = 1'b0;
    for (int i = 0; i < 20; i++) chk("s6_done_held", 3, 4 * UNIT, 0, 1, 0);
    game_started = 1'b0;
    chk("s6_exit", 0, -1, 0, 0, 0);
    start_round("s6r", 1, 1, UNIT);
    chk("s6r_run", 2, UNIT, 0, 0, 0);
    chk("s6r_run", 2, UNIT, 0, 0, 0);
    reset = 1'b1;
    chk("s6_reset_mid_seek", 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("s6_rise_after_reset", 1, HS, 0, 0, 0);
    game_started = 1'b0;
    chk("s6_final_abort", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
